// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RV32I-subset core: sequences the instruction
// phases, decodes the ALU configuration, counts retired instructions, halts on illegal encodings.
module multicycle_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  output logic [3:0]  estado,
  output logic        alusrc,
  output logic [3:0]  alucontrol,
  output logic [11:0] immediate,
  output logic        negativo,
  output logic        branch,
  output logic        regwrite,
  output logic        memtoreg,
  output logic        memread,
  output logic        memwrite,
  output logic        iord,
  output logic        irwrite,
  output logic        pcwrite,
  output logic        halted,
  output logic [31:0] instret
);

  typedef enum logic [3:0] {
    FETCH      = 4'b0000,
    IR_LOAD    = 4'b0001,
    DECODE     = 4'b0010,
    EXEC_ARITH = 4'b0101,
    EXEC_MEMBR = 4'b0110,
    WB_ALU     = 4'b0111,
    MEM_RD     = 4'b1000,
    WB_MEM     = 4'b1001,
    MEM_WR     = 4'b1010,
    BR_RESOLVE = 4'b1011,
    STORE_DONE = 4'b1100,
    HALT       = 4'b1111
  } state_t;

  typedef enum logic [1:0] {
    KIND_ARITH  = 2'd0,
    KIND_LOAD   = 2'd1,
    KIND_STORE  = 2'd2,
    KIND_BRANCH = 2'd3
  } kind_t;

  state_t      state_q, state_d;
  kind_t       kind_q, decKind;
  logic        alusrc_q;
  logic [3:0]  alucontrol_q;
  logic [11:0] immediate_q;
  logic        negativo_q;
  logic [31:0] instret_q;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        decLegal;
  logic        decAluSrc;
  logic [3:0]  decAluCtl;
  logic [11:0] rawImm;
  logic [11:0] decMag;
  logic        unused_rs1;

  assign opcode     = instr[6:0];
  assign funct3     = instr[14:12];
  assign funct7     = instr[31:25];
  assign unused_rs1 = ^instr[19:15];

  // Instruction decode; anything not explicitly recognised stays illegal.
  always_comb begin
    decLegal  = 1'b0;
    decKind   = KIND_ARITH;
    decAluSrc = 1'b0;
    decAluCtl = 4'b0000;
    rawImm    = 12'h000;
    case (opcode)
      7'b0110011: begin
        if (funct7 == 7'b0000000) begin
          decLegal = 1'b1;
          case (funct3)
            3'b000:  decAluCtl = 4'b0010;
            3'b111:  decAluCtl = 4'b0000;
            3'b110:  decAluCtl = 4'b0001;
            3'b100:  decAluCtl = 4'b0100;
            3'b101:  decAluCtl = 4'b0101;
            default: decLegal  = 1'b0;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          decLegal  = 1'b1;
          decAluCtl = 4'b0110;
        end
      end
      7'b0010011: begin
        if (funct3 == 3'b000) begin
          decLegal  = 1'b1;
          decAluSrc = 1'b1;
          decAluCtl = 4'b0011;
          rawImm    = instr[31:20];
        end
      end
      7'b0000011: begin
        if (funct3 == 3'b010) begin
          decLegal  = 1'b1;
          decKind   = KIND_LOAD;
          decAluSrc = 1'b1;
          decAluCtl = 4'b0010;
          rawImm    = instr[31:20];
        end
      end
      7'b0100011: begin
        if (funct3 == 3'b010) begin
          decLegal  = 1'b1;
          decKind   = KIND_STORE;
          decAluSrc = 1'b1;
          decAluCtl = 4'b0010;
          rawImm    = {instr[31:25], instr[11:7]};
        end
      end
      7'b1100011: begin
        if (funct3 == 3'b000 || funct3 == 3'b001) begin
          decLegal  = 1'b1;
          decKind   = KIND_BRANCH;
          decAluSrc = 1'b1;
          decAluCtl = (funct3 == 3'b000) ? 4'b0110 : 4'b1111;
          rawImm    = {instr[31], instr[7], instr[30:25], instr[11:8]};
        end
      end
      default: decLegal = 1'b0;
    endcase
  end

  // Two's-complement negate wraps 0x800 onto itself, as the ALU expects.
  assign decMag = rawImm[11] ? (~rawImm + 12'd1) : rawImm;

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:      if (mem_ready) state_d = IR_LOAD;
      IR_LOAD:    state_d = DECODE;
      DECODE: begin
        if (!decLegal)                state_d = HALT;
        else if (decKind == KIND_ARITH) state_d = EXEC_ARITH;
        else                          state_d = EXEC_MEMBR;
      end
      EXEC_ARITH: state_d = WB_ALU;
      EXEC_MEMBR: begin
        case (kind_q)
          KIND_LOAD:  state_d = MEM_RD;
          KIND_STORE: state_d = MEM_WR;
          default:    state_d = BR_RESOLVE;
        endcase
      end
      WB_ALU:     state_d = FETCH;
      MEM_RD:     if (mem_ready) state_d = WB_MEM;
      WB_MEM:     state_d = FETCH;
      MEM_WR:     if (mem_ready) state_d = STORE_DONE;
      STORE_DONE: state_d = FETCH;
      BR_RESOLVE: state_d = FETCH;
      HALT:       state_d = HALT;
      default:    state_d = HALT;
    endcase
  end

  always_comb begin
    branch   = 1'b0;
    regwrite = 1'b0;
    memtoreg = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    iord     = 1'b0;
    irwrite  = 1'b0;
    pcwrite  = 1'b0;
    halted   = 1'b0;
    case (state_q)
      FETCH:      memread = 1'b1;
      IR_LOAD:    irwrite = 1'b1;
      MEM_RD:     begin memread = 1'b1; iord = 1'b1; end
      MEM_WR:     begin memwrite = 1'b1; iord = 1'b1; end
      WB_ALU:     begin regwrite = 1'b1; pcwrite = 1'b1; end
      WB_MEM:     begin regwrite = 1'b1; memtoreg = 1'b1; pcwrite = 1'b1; end
      STORE_DONE: pcwrite = 1'b1;
      BR_RESOLVE: begin branch = 1'b1; pcwrite = 1'b1; end
      HALT:       halted = 1'b1;
      default:    ;
    endcase
  end

  // Decoded fields are captured on the edge leaving DECODE and held for the whole instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FETCH;
      kind_q       <= KIND_ARITH;
      alusrc_q     <= 1'b0;
      alucontrol_q <= 4'b0000;
      immediate_q  <= 12'h000;
      negativo_q   <= 1'b0;
      instret_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      if (pcwrite) instret_q <= instret_q + 32'd1;
      if (state_q == DECODE) begin
        kind_q       <= decKind;
        alusrc_q     <= decAluSrc;
        alucontrol_q <= decAluCtl;
        immediate_q  <= decMag;
        negativo_q   <= rawImm[11];
      end
    end
  end

  assign estado     = state_q;
  assign alusrc     = alusrc_q;
  assign alucontrol = alucontrol_q;
  assign immediate  = immediate_q;
  assign negativo   = negativo_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the driver queues the hand-computed expected
// outputs of each cycle and a monitor compares them on the falling edge.
module tb_multicycle_control;

  localparam logic [3:0] S_FETCH = 4'b0000, S_IR = 4'b0001, S_DEC = 4'b0010,
                         S_EXA = 4'b0101, S_EXM = 4'b0110, S_WBA = 4'b0111,
                         S_MRD = 4'b1000, S_WBM = 4'b1001, S_MWR = 4'b1010,
                         S_BR = 4'b1011, S_SD = 4'b1100, S_HALT = 4'b1111;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        mem_ready;
  logic [3:0]  estado;
  logic        alusrc;
  logic [3:0]  alucontrol;
  logic [11:0] immediate;
  logic        negativo;
  logic        branch, regwrite, memtoreg, memread, memwrite, iord, irwrite, pcwrite;
  logic        halted;
  logic [31:0] instret;

  typedef struct {
    int          step;
    logic [3:0]  st;
    logic [31:0] instret;
    bit          chkDec;
    logic        aluSrc;
    logic [3:0]  aluCtl;
    logic [11:0] imm;
    logic        neg;
  } expT;

  expT expQ[$];
  int  testsRun = 0;
  int  testsFailed = 0;
  int  stepNo = 0;

  logic        expAluSrc;
  logic [3:0]  expAluCtl;
  logic [11:0] expImm;
  logic        expNeg;
  logic [31:0] expInstret;
  bit          decKnown;

  multicycle_control dut (
    .clk(clk), .reset(reset), .instr(instr), .mem_ready(mem_ready),
    .estado(estado), .alusrc(alusrc), .alucontrol(alucontrol),
    .immediate(immediate), .negativo(negativo), .branch(branch),
    .regwrite(regwrite), .memtoreg(memtoreg), .memread(memread),
    .memwrite(memwrite), .iord(iord), .irwrite(irwrite), .pcwrite(pcwrite),
    .halted(halted), .instret(instret)
  );

  always #5 clk = ~clk;

  // Expected strobe vector {branch,regwrite,memtoreg,memread,memwrite,iord,irwrite,pcwrite,halted}
  function automatic logic [8:0] strobesFor(input logic [3:0] st);
    case (st)
      S_FETCH: return 9'b000100000;
      S_IR:    return 9'b000000100;
      S_MRD:   return 9'b000101000;
      S_MWR:   return 9'b000011000;
      S_WBA:   return 9'b010000010;
      S_WBM:   return 9'b011000010;
      S_SD:    return 9'b000000010;
      S_BR:    return 9'b100000010;
      S_HALT:  return 9'b000000001;
      default: return 9'b000000000;
    endcase
  endfunction

  task automatic checkOutput(input expT e);
    logic [8:0] act;
    logic [8:0] req;
    logic       bad;
    act = {branch, regwrite, memtoreg, memread, memwrite, iord, irwrite, pcwrite, halted};
    req = strobesFor(e.st);
    bad = 1'b0;
    testsRun++;
    if (estado !== e.st || act !== req || instret !== e.instret) bad = 1'b1;
    if (e.chkDec && ({alusrc, alucontrol, immediate, negativo} !== {e.aluSrc, e.aluCtl, e.imm, e.neg}))
      bad = 1'b1;
    if (bad) begin
      testsFailed++;
      $display("[TB] FAIL step%0d: estado=%b (exp %b) strobes=%b (exp %b) instret=%0d (exp %0d) dec=%b/%b/%h/%b (exp %b/%b/%h/%b chk=%0d)",
               e.step, estado, e.st, act, req, instret, e.instret,
               alusrc, alucontrol, immediate, negativo,
               e.aluSrc, e.aluCtl, e.imm, e.neg, e.chkDec);
    end
  endtask

  // Monitor: one expected record per observed cycle, compared mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  // Drive one cycle's inputs and queue what the DUT must show during this cycle.
  task automatic applyStimulus(input logic rstV, input logic [31:0] instrV, input logic mrV,
                               input logic [3:0] expSt, input bit chk);
    expT e;
    reset     = rstV;
    instr     = instrV;
    mem_ready = mrV;
    if (chk) begin
      e.step    = stepNo;
      e.st      = expSt;
      e.instret = expInstret;
      e.chkDec  = decKnown;
      e.aluSrc  = expAluSrc;
      e.aluCtl  = expAluCtl;
      e.imm     = expImm;
      e.neg     = expNeg;
      expQ.push_back(e);
    end
    stepNo++;
    @(posedge clk);
    #1;
  endtask

  task automatic setDec(input logic s, input logic [3:0] c, input logic [11:0] im, input logic n);
    expAluSrc = s; expAluCtl = c; expImm = im; expNeg = n; decKnown = 1'b1;
  endtask

  task automatic frontEnd(input logic [31:0] ins, input int fetchWaits);
    for (int i = 0; i < fetchWaits; i++) applyStimulus(1'b0, ins, 1'b0, S_FETCH, 1'b1);
    applyStimulus(1'b0, ins, 1'b1, S_FETCH, 1'b1);
    applyStimulus(1'b0, ins, 1'b0, S_IR, 1'b1);
    applyStimulus(1'b0, ins, 1'b0, S_DEC, 1'b1);
  endtask

  task automatic runArith(input logic [31:0] ins, input logic s, input logic [3:0] c,
                          input logic [11:0] im, input logic n);
    frontEnd(ins, 0);
    setDec(s, c, im, n);
    applyStimulus(1'b0, ins, 1'b0, S_EXA, 1'b1);
    applyStimulus(1'b0, ins, 1'b0, S_WBA, 1'b1);
    expInstret++;
  endtask

  task automatic runLoad(input logic [31:0] ins, input logic [11:0] im, input logic n, input int waits);
    frontEnd(ins, 0);
    setDec(1'b1, 4'b0010, im, n);
    applyStimulus(1'b0, ins, 1'b0, S_EXM, 1'b1);
    for (int i = 0; i < waits; i++) applyStimulus(1'b0, ins, 1'b0, S_MRD, 1'b1);
    applyStimulus(1'b0, ins, 1'b1, S_MRD, 1'b1);
    applyStimulus(1'b0, ins, 1'b0, S_WBM, 1'b1);
    expInstret++;
  endtask

  task automatic runStore(input logic [31:0] ins, input logic [11:0] im, input logic n);
    frontEnd(ins, 0);
    setDec(1'b1, 4'b0010, im, n);
    applyStimulus(1'b0, ins, 1'b1, S_EXM, 1'b1);
    applyStimulus(1'b0, ins, 1'b1, S_MWR, 1'b1);
    applyStimulus(1'b0, ins, 1'b0, S_SD, 1'b1);
    expInstret++;
  endtask

  task automatic runBranch(input logic [31:0] ins, input logic [3:0] c, input logic [11:0] im,
                           input logic n, input int fetchWaits);
    frontEnd(ins, fetchWaits);
    setDec(1'b1, c, im, n);
    applyStimulus(1'b0, ins, 1'b0, S_EXM, 1'b1);
    applyStimulus(1'b0, ins, 1'b0, S_BR, 1'b1);
    expInstret++;
  endtask

  // Reset values: decode cleared, counter zero.
  task automatic expectResetState();
    setDec(1'b0, 4'b0000, 12'h000, 1'b0);
    expInstret = 32'd0;
  endtask

  initial begin
    decKnown   = 1'b0;
    expInstret = 32'd0;
    expAluSrc  = 1'b0; expAluCtl = 4'b0000; expImm = 12'h000; expNeg = 1'b0;

    applyStimulus(1'b1, 32'h0, 1'b1, S_FETCH, 1'b0);
    applyStimulus(1'b1, 32'h0, 1'b1, S_FETCH, 1'b0);
    expectResetState();

    runArith(32'h002081B3, 1'b0, 4'b0010, 12'h000, 1'b0);   // add x3,x1,x2
    runArith(32'hFFB00093, 1'b1, 4'b0011, 12'h005, 1'b1);   // addi x1,x0,-5
    runLoad (32'h00812283, 12'h008, 1'b0, 3);               // lw x5,8(x2)
    runStore(32'hFE512E23, 12'h004, 1'b1);                  // sw x5,-4(x2)
    runBranch(32'h00209463, 4'b1111, 12'h004, 1'b0, 2);     // bne x1,x2,+8 after fetch waits
    runBranch(32'h00208463, 4'b0110, 12'h004, 1'b0, 0);     // beq x1,x2,+8

    // Second sw stalled in MEM_WR, then reset during the stall.
    frontEnd(32'hFE512E23, 0);
    setDec(1'b1, 4'b0010, 12'h004, 1'b1);
    applyStimulus(1'b0, 32'hFE512E23, 1'b0, S_EXM, 1'b1);
    applyStimulus(1'b0, 32'hFE512E23, 1'b0, S_MWR, 1'b1);
    applyStimulus(1'b1, 32'hFE512E23, 1'b1, S_MWR, 1'b1);
    expectResetState();

    runArith(32'h0020F1B3, 1'b0, 4'b0000, 12'h000, 1'b0);   // and
    runArith(32'h402081B3, 1'b0, 4'b0110, 12'h000, 1'b0);   // sub

    // Illegal all-ones word: sticky HALT, counter frozen, mem_ready ignored.
    frontEnd(32'hFFFFFFFF, 0);
    decKnown = 1'b0;
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 32'hFFFFFFFF, i[0], S_HALT, 1'b1);
    applyStimulus(1'b1, 32'hFFFFFFFF, 1'b1, S_HALT, 1'b1);
    expectResetState();

    // and with a non-zero funct7 is illegal too.
    frontEnd(32'h4020F1B3, 0);
    decKnown = 1'b0;
    applyStimulus(1'b0, 32'h4020F1B3, 1'b1, S_HALT, 1'b1);
    applyStimulus(1'b1, 32'h4020F1B3, 1'b1, S_HALT, 1'b1);
    expectResetState();
    applyStimulus(1'b0, 32'h0, 1'b0, S_FETCH, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, S_FETCH, 1'b1);

    @(negedge clk);
    #1;
    testsRun++;
    if (expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL scoreboard drain: %0d entries left, expected 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control unit for the multicycle RV32I-subset core. It sequences fetch, decode, execute, memory and writeback and drives the `estado` code that the ALU uses to gate its execution cycles. It also decodes the instruction register into the ALU configuration: `alusrc`, `alucontrol`, magnitude/sign immediate.
- Handshakes with a variable-latency memory.
- Counts retired instructions.
- Halts on illegal encodings.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `instr`  in  32  instruction register contents; valid from DECODE onward.
- `mem_ready`  in  1  memory completion for current read/write request.
- `estado`  out  4  current state code.
- `alusrc`  out  1  0 = register operand B, 1 = immediate.
- `alucontrol`  out  4  ALU operation code.
- `immediate`  out  12  immediate magnitude (unsigned).
- `negativo`  out  1  immediate sign.
- `branch`  out  1  branch-resolve cycle.
- `regwrite`, `memtoreg`, `memread`, `memwrite`, `iord`, `irwrite`, `pcwrite`  out  1 each  datapath strobes.
- `halted`  out  1  sticky illegal-instruction flag.
- `instret`  out  32  retired-instruction counter.

## Operation
- States (`estado`):
  - FETCH = 0000
  - IR_LOAD = 0001
  - DECODE = 0010
  - EXEC_ARITH = 0101
  - EXEC_MEMBR = 0110
  - WB_ALU = 0111
  - MEM_RD = 1000
  - WB_MEM = 1001
  - MEM_WR = 1010
  - BR_RESOLVE = 1011
  - STORE_DONE = 1100
  - HALT = 1111
- Transitions:
  - FETCH goes to IR_LOAD when `mem_ready`=1; otherwise it holds.
  - IR_LOAD goes to DECODE.
  - DECODE goes to EXEC_ARITH (R-type, addi), EXEC_MEMBR (lw, sw, beq, bne) or HALT (anything else).
  - EXEC_ARITH goes to WB_ALU, then to FETCH.
  - EXEC_MEMBR goes to MEM_RD (lw), MEM_WR (sw) or BR_RESOLVE (branches).
  - MEM_RD goes to WB_MEM when `mem_ready`=1; WB_MEM then goes to FETCH.
  - MEM_WR goes to STORE_DONE when `mem_ready`=1; STORE_DONE then goes to FETCH.
  - BR_RESOLVE goes to FETCH.
  - HALT holds until reset.
- Strobes are a Moore decode of the state:
  - FETCH: `memread`=1, `iord`=0.
  - IR_LOAD: `irwrite`.
  - MEM_RD: `memread`=1, `iord`=1.
  - MEM_WR: `memwrite`=1, `iord`=1.
  - WB_ALU: `regwrite`, `pcwrite`.
  - WB_MEM: `regwrite`, `memtoreg`, `pcwrite`.
  - STORE_DONE: `pcwrite`.
  - BR_RESOLVE: `branch`, `pcwrite`.
  - HALT: `halted`.
  - All other strobes are 0.
- Decode is registered at the DECODE edge and held constant until the next DECODE. Opcode is `instr[6:0]`.
- R-type, 0110011 (`alusrc`=0; illegal if funct7 ≠ 0000000 unless noted):
  - add = f3 000 / f7 0000000 → 0010
  - sub = 000 / 0100000 → 0110
  - and = 111 → 0000
  - or = 110 → 0001
  - xor = 100 → 0100
  - srl = 101 → 0101
- Immediate forms (`alusrc`=1):
  - addi: 0010011 with f3 000 → 0011
  - lw: 0000011 with f3 010 → 0010
  - sw: 0100011 with f3 010 → 0010
  - beq: 1100011 with f3 000 → 0110
  - bne: 1100011 with f3 001 → 1111
- Raw 12-bit immediate:
  - I-type: `instr[31:20]`
  - S-type: {`instr[31:25]`, `instr[11:7]`}
  - B-type: {`instr[31]`, `instr[7]`, `instr[30:25]`, `instr[11:8]`}
  - R-type: 0
- Sign/magnitude conversion: `negativo` = raw[11]; `immediate` = raw[11] ? (~raw + 1) mod 4096 : raw.
  - Raw 0x800 gives `immediate`=0x800, `negativo`=1.
- `instret` increments by 1 on every cycle with `pcwrite`=1 and wraps 0xFFFFFFFF → 0. HALT never increments it.

## Timing
- Reset (sampled on a rising edge):
  - `estado`=0000.
  - `alusrc`=0, `alucontrol`=0000, `immediate`=0, `negativo`=0.
  - `halted`=0, `instret`=0.
  - Strobes then follow FETCH decode: `memread`=1 in the first cycle after reset.
- Reset has priority over every transition, including mid-handshake: reset in MEM_WR drops `memwrite` the next cycle with no `pcwrite`.
- Latency with `mem_ready` tied 1:
  - ALU op: 5 cycles (FETCH, IR_LOAD, DECODE, EXEC, WB_ALU).
  - sw: 6 cycles; lw: 6 cycles; branch: 5 cycles.
  - Each `mem_ready`=0 cycle in FETCH, MEM_RD or MEM_WR adds one cycle; strobes stay asserted while waiting.
- `mem_ready` is ignored outside FETCH, MEM_RD and MEM_WR.
- The ALU result registers on the edge ending EXEC_*. WB_ALU, MEM_* and BR_RESOLVE see a stable result and `pcsrc`.
- Decoded fields are stable from the first EXEC cycle through the last cycle of the instruction.

## Test plan
- Reset, then add x3,x1,x2 (0x002081B3), `mem_ready`=1:
  - `estado` goes 0000, 0001, 0010, 0101, 0111, 0000.
  - `alucontrol`=0010, `alusrc`=0.
  - `regwrite`/`pcwrite` are high only in 0111.
  - `instret`=1.
- addi x1,x0,-5 (0xFFB00093):
  - `alusrc`=1, `alucontrol`=0011, `immediate`=0x005, `negativo`=1.
  - `estado` 0101 then 0111.
- lw x5,8(x2) (0x00812283), `mem_ready`=0 for 3 cycles in MEM_RD:
  - `estado`=1000 with `memread`=`iord`=1 for 4 cycles.
  - Then 1001 with `regwrite`=`memtoreg`=`pcwrite`=1.
  - `immediate`=8, `negativo`=0.
- sw x5,-4(x2) (0xFE512E23):
  - `immediate`=4, `negativo`=1, `alucontrol`=0010.
  - `estado` 0110, 1010, 1100.
  - `memwrite` high only in 1010.
  - Assert reset during a second sw held in MEM_WR: the next state is 0000, `memwrite`=0, `instret`=0.
- bne x1,x2,+8 (0x00209463):
  - `alucontrol`=1111, `alusrc`=1, `immediate`=0x004, `negativo`=0.
  - 0110 then 1011 with `branch`=`pcwrite`=1.
- Illegal 0xFFFFFFFF:
  - `estado`=1111, `halted`=1, all strobes 0 for 10+ cycles, `instret` unchanged.
  - Reset returns to 0000 with `halted`=0.
